idli_sqi_arb_m: RTL and testbench

Shared quad-serial (SQI) memory port controller. Arbitrates between instruction fetch and the execution unit's load/store requests, then sequences one fixed-format SQI transaction per grant (command, address, dummy, data) over a 4-bit bus. Data moves nibble-serially to match the four-cycle, 16b execution datapath. Sits between the fetch/EX units and the external SQI SRAM pins.

---
 rtl/idli_pkg.sv | 55 +++++
 rtl/idli_rr_arb_m.sv | 41 ++++
 rtl/idli_sqi_arb_m.sv | 131 +++++++++++++
 tb/tb_idli_sqi_arb_m.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types and constants for the SQI memory port controller.
// Command bytes, per-state cycle counts and nibble helpers live here.
package idli_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    DUMMY = 3'd3,
    DATA  = 3'd4,
    GAP   = 3'd5
  } sqi_state_t;

  typedef enum logic {
    FE = 1'b0,
    EX = 1'b1
  } sqi_owner_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  localparam logic [2:0] SQI_CMD_CYC   = 3'd2;
  localparam logic [2:0] SQI_ADDR_CYC  = 3'd4;
  localparam logic [2:0] SQI_DUMMY_CYC = 3'd2;
  localparam logic [2:0] SQI_DATA_CYC  = 3'd4;
  localparam logic [2:0] SQI_GAP_CYC   = 3'd1;

  // Index 0 selects the most significant nibble.
  function automatic logic [3:0] nib_sel(
    input logic [15:0] w,
    input logic [1:0]  i
  );
    logic [3:0] n;
    case (i)
      2'd0:    n = w[15:12];
      2'd1:    n = w[11:8];
      2'd2:    n = w[7:4];
      default: n = w[3:0];
    endcase
    return n;
  endfunction

  function automatic logic [2:0] state_len(input sqi_state_t s);
    logic [2:0] n;
    case (s)
      CMD:     n = SQI_CMD_CYC;
      ADDR:    n = SQI_ADDR_CYC;
      DUMMY:   n = SQI_DUMMY_CYC;
      DATA:    n = SQI_DATA_CYC;
      default: n = SQI_GAP_CYC;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/idli_rr_arb_m.sv
// Two-way round-robin arbiter between fetch and EX.
// The last-owner flop breaks ties in favour of the other requester.
module idli_rr_arb_m
  import idli_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_fe,
  input  logic req_ex,
  output logic gnt_fe,
  output logic gnt_ex
);

  sqi_owner_t last;

  always_comb begin
    gnt_fe = 1'b0;
    gnt_ex = 1'b0;
    if (en) begin
      if (req_fe && req_ex) begin
        gnt_fe = (last == EX);
        gnt_ex = (last == FE);
      end else begin
        gnt_fe = req_fe;
        gnt_ex = req_ex;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= EX;
    end else if (gnt_fe) begin
      last <= FE;
    end else if (gnt_ex) begin
      last <= EX;
    end
  end

endmodule

// File: rtl/idli_sqi_arb_m.sv
// Shared SQI memory port: arbitrates fetch vs EX and sequences
// one command/address/dummy/data transaction per grant.
module idli_sqi_arb_m
  import idli_pkg::*;
(
  input  logic        i_mem_gck,
  input  logic        i_mem_rst,
  input  logic        i_mem_fe_req,
  input  logic [15:0] i_mem_fe_addr,
  output logic        o_mem_fe_gnt,
  output logic        o_mem_fe_rvld,
  input  logic        i_mem_ex_req,
  input  logic        i_mem_ex_wr,
  input  logic [15:0] i_mem_ex_addr,
  input  logic [15:0] i_mem_ex_wdata,
  output logic        o_mem_ex_gnt,
  output logic        o_mem_ex_rvld,
  output logic [3:0]  o_mem_rdata,
  output logic        o_mem_busy,
  output logic        o_mem_cs_n,
  output logic        o_mem_sio_oe,
  output logic [3:0]  o_mem_sio,
  input  logic [3:0]  i_mem_sio
);

  sqi_state_t state;
  sqi_state_t nxt;
  sqi_owner_t owner;
  logic [2:0]  cnt;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        wr;
  logic        gnt_fe;
  logic        gnt_ex;
  logic        arb_en;
  logic        last_cyc;
  logic        rd_data;
  logic [7:0]  cmd;

  // Gating with reset keeps the grant low while reset is held.
  assign arb_en = (state == IDLE) && !i_mem_rst;

  idli_rr_arb_m u_arb (
    .clk    (i_mem_gck),
    .rst    (i_mem_rst),
    .en     (arb_en),
    .req_fe (i_mem_fe_req),
    .req_ex (i_mem_ex_req),
    .gnt_fe (gnt_fe),
    .gnt_ex (gnt_ex)
  );

  assign last_cyc = (cnt == state_len(state) - 3'd1);

  always_comb begin
    nxt = state;
    unique case (state)
      CMD:     nxt = ADDR;
      ADDR:    nxt = wr ? DATA : DUMMY;
      DUMMY:   nxt = DATA;
      DATA:    nxt = GAP;
      GAP:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_mem_gck) begin
    if (i_mem_rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      owner <= EX;
      addr  <= 16'h0;
      wdata <= 16'h0;
      wr    <= 1'b0;
    end else if (state == IDLE) begin
      if (gnt_fe || gnt_ex) begin
        state <= CMD;
        cnt   <= 3'd0;
        owner <= gnt_fe ? FE : EX;
        addr  <= gnt_fe ? i_mem_fe_addr : i_mem_ex_addr;
        wr    <= gnt_ex && i_mem_ex_wr;
        wdata <= i_mem_ex_wdata;
      end
    end else if (last_cyc) begin
      state <= nxt;
      cnt   <= 3'd0;
    end else begin
      cnt <= cnt + 3'd1;
    end
  end

  assign cmd     = wr ? SQI_CMD_WRITE : SQI_CMD_READ;
  assign rd_data = (state == DATA) && !wr;

  always_comb begin
    o_mem_cs_n   = 1'b1;
    o_mem_sio_oe = 1'b0;
    o_mem_sio    = 4'h0;
    unique case (state)
      CMD: begin
        o_mem_cs_n   = 1'b0;
        o_mem_sio_oe = 1'b1;
        o_mem_sio    = cnt[0] ? cmd[3:0] : cmd[7:4];
      end
      ADDR: begin
        o_mem_cs_n   = 1'b0;
        o_mem_sio_oe = 1'b1;
        o_mem_sio    = nib_sel(addr, cnt[1:0]);
      end
      DUMMY: begin
        o_mem_cs_n = 1'b0;
      end
      DATA: begin
        o_mem_cs_n   = 1'b0;
        o_mem_sio_oe = wr;
        o_mem_sio    = wr ? nib_sel(wdata, cnt[1:0]) : 4'h0;
      end
      default: begin
        o_mem_cs_n = 1'b1;
      end
    endcase
  end

  assign o_mem_fe_gnt  = gnt_fe;
  assign o_mem_ex_gnt  = gnt_ex;
  assign o_mem_rdata   = rd_data ? i_mem_sio : 4'h0;
  assign o_mem_fe_rvld = rd_data && (owner == FE);
  assign o_mem_ex_rvld = rd_data && (owner == EX);
  assign o_mem_busy    = (state != IDLE);

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Directed bench for the SQI port controller.
// Each step drives inputs after a rising edge and checks before the next.
module tb_idli_sqi_arb_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        fe_req;
  logic [15:0] fe_addr;
  logic        fe_gnt;
  logic        fe_rvld;
  logic        ex_req;
  logic        ex_wr;
  logic [15:0] ex_addr;
  logic [15:0] ex_wdata;
  logic        ex_gnt;
  logic        ex_rvld;
  logic [3:0]  rdata;
  logic        busy;
  logic        cs_n;
  logic        sio_oe;
  logic [3:0]  sio_out;
  logic [3:0]  sio_in;

  int n_assert = 0;
  int n_fail   = 0;

  idli_sqi_arb_m dut (
    .i_mem_gck      (clk),
    .i_mem_rst      (rst),
    .i_mem_fe_req   (fe_req),
    .i_mem_fe_addr  (fe_addr),
    .o_mem_fe_gnt   (fe_gnt),
    .o_mem_fe_rvld  (fe_rvld),
    .i_mem_ex_req   (ex_req),
    .i_mem_ex_wr    (ex_wr),
    .i_mem_ex_addr  (ex_addr),
    .i_mem_ex_wdata (ex_wdata),
    .o_mem_ex_gnt   (ex_gnt),
    .o_mem_ex_rvld  (ex_rvld),
    .o_mem_rdata    (rdata),
    .o_mem_busy     (busy),
    .o_mem_cs_n     (cs_n),
    .o_mem_sio_oe   (sio_oe),
    .o_mem_sio      (sio_out),
    .i_mem_sio      (sio_in)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_cs_n"}, 16'(cs_n), 16'h1);
    chk({tag, "_oe"}, 16'(sio_oe), 16'h0);
    chk({tag, "_sio"}, 16'(sio_out), 16'h0);
    chk({tag, "_rdata"}, 16'(rdata), 16'h0);
    chk({tag, "_gnt"}, {14'h0, fe_gnt, ex_gnt}, 16'h0);
    chk({tag, "_rvld"}, {14'h0, fe_rvld, ex_rvld}, 16'h0);
    chk({tag, "_busy"}, 16'(busy), 16'h0);
  endtask

  logic [3:0] exp_a [6]  = '{4'h0, 4'h3, 4'h1, 4'h2, 4'h3, 4'h4};
  logic [3:0] rd_a  [4]  = '{4'hB, 4'hE, 4'hE, 4'hF};
  logic [3:0] exp_b [10] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'hF,
                             4'hF, 4'hA, 4'h5, 4'hC, 4'h3};

  int  last_c;
  int  ng;
  int  w;
  logic last_fe;
  logic ex_seen;

  initial begin
    rst      = 1'b1;
    fe_req   = 1'b1;
    ex_req   = 1'b1;
    ex_wr    = 1'b0;
    fe_addr  = 16'h0;
    ex_addr  = 16'h0;
    ex_wdata = 16'h0;
    sio_in   = 4'hF;

    // Reset state, with requests held to show grants stay low.
    tick();
    tick();
    #1;
    chk_rst("rst");

    // Fetch read of 0x1234 returning 0xBEEF.
    tick();
    rst     = 1'b0;
    ex_req  = 1'b0;
    fe_req  = 1'b1;
    fe_addr = 16'h1234;
    sio_in  = 4'h0;
    #1;
    chk("a_gnt", 16'(fe_gnt), 16'h1);
    chk("a_busy_g", 16'(busy), 16'h0);
    for (int k = 1; k <= 14; k++) begin
      tick();
      fe_req = 1'b0;
      sio_in = (k >= 9 && k <= 12) ? rd_a[k-9] : 4'h0;
      #1;
      if (k <= 6) begin
        chk("a_sio", 16'(sio_out), 16'(exp_a[k-1]));
        chk("a_oe", {15'h0, sio_oe}, 16'h1);
        chk("a_cs", {15'h0, cs_n}, 16'h0);
      end else if (k <= 8) begin
        chk("a_dummy", {11'h0, sio_oe, sio_out}, 16'h0);
        chk("a_cs_d", {15'h0, cs_n}, 16'h0);
      end else if (k <= 12) begin
        chk("a_rdata", 16'(rdata), 16'(rd_a[k-9]));
        chk("a_rvld", {14'h0, fe_rvld, ex_rvld}, 16'h2);
        chk("a_oe_r", {15'h0, sio_oe}, 16'h0);
      end else if (k == 13) begin
        chk("a_gap", {14'h0, cs_n, busy}, 16'h3);
        chk("a_rvld_g", {14'h0, fe_rvld, ex_rvld}, 16'h0);
      end else begin
        chk("a_idle", 16'(busy), 16'h0);
      end
    end

    // EX write 0xA5C3 to 0x00FF, granted in the IDLE cycle above.
    ex_req   = 1'b1;
    ex_wr    = 1'b1;
    ex_addr  = 16'h00FF;
    ex_wdata = 16'hA5C3;
    #1;
    chk("b_gnt", {14'h0, fe_gnt, ex_gnt}, 16'h1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      ex_req   = 1'b0;
      ex_wdata = 16'h0;
      #1;
      if (k <= 10) begin
        chk("b_sio", 16'(sio_out), 16'(exp_b[k-1]));
        chk("b_oe_cs", {14'h0, sio_oe, cs_n}, 16'h2);
        chk("b_rvld", {14'h0, fe_rvld, ex_rvld}, 16'h0);
      end else if (k == 11) begin
        chk("b_gap", {14'h0, cs_n, busy}, 16'h3);
      end else begin
        chk("b_idle", 16'(busy), 16'h0);
      end
    end

    // Both requesting from reset: FE, EX, FE, ... alternating.
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    fe_req = 1'b1;
    ex_req = 1'b1;
    ex_wr  = 1'b1;
    #1;
    last_c  = -1;
    last_fe = 1'b0;
    ng      = 0;
    for (int c = 0; c < 60; c++) begin
      if (fe_gnt || ex_gnt) begin
        chk("c_fe", 16'(fe_gnt), 16'(ng % 2 == 0));
        chk("c_ex", 16'(ex_gnt), 16'(ng % 2 == 1));
        if (last_c >= 0)
          chk("c_gap", 16'(c - last_c), last_fe ? 16'd14 : 16'd12);
        last_c  = c;
        last_fe = fe_gnt;
        ng++;
      end
      if (c < 59) begin
        tick();
        #1;
      end
    end
    chk("c_ngnt", 16'(ng), 16'd5);
    fe_req = 1'b0;
    ex_req = 1'b0;
    w = 0;
    while (busy && w < 30) begin
      tick();
      #1;
      w++;
    end
    chk("c_idle", 16'(busy), 16'h0);

    // Fetch alone, back-to-back three times.
    fe_req  = 1'b1;
    fe_addr = 16'h4000;
    #1;
    last_c  = -1;
    ng      = 0;
    ex_seen = 1'b0;
    for (int c = 0; c < 42; c++) begin
      if (ex_gnt) ex_seen = 1'b1;
      if (fe_gnt) begin
        if (last_c >= 0)
          chk("d_gap", 16'(c - last_c), 16'd14);
        last_c = c;
        ng++;
      end
      if (c < 41) begin
        tick();
        #1;
      end
    end
    chk("d_ngnt", 16'(ng), 16'd3);
    chk("d_ex", 16'(ex_seen), 16'h0);
    tick();
    fe_req = 1'b0;
    #1;
    chk("d_idle", 16'(busy), 16'h0);

    // Fetch read aborted by reset in its DATA phase; EX waits.
    fe_req  = 1'b1;
    fe_addr = 16'h0100;
    #1;
    chk("e_gnt", 16'(fe_gnt), 16'h1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      fe_req = 1'b0;
      if (k == 1) begin
        ex_req  = 1'b1;
        ex_wr   = 1'b0;
        ex_addr = 16'h2222;
      end
      sio_in = 4'h9;
      #1;
      if (k >= 9) chk("e_rvld", 16'(fe_rvld), 16'h1);
      if (k == 10) rst = 1'b1;
    end
    tick();
    #1;
    chk_rst("e_rst");
    tick();
    rst = 1'b0;
    #1;
    chk("e_regnt", {14'h0, fe_gnt, ex_gnt}, 16'h1);
    chk("e_norvld", {14'h0, fe_rvld, ex_rvld}, 16'h0);

    // EX read in flight; fetch raised during DATA waits for IDLE.
    for (int k = 1; k <= 14; k++) begin
      tick();
      ex_req = 1'b0;
      if (k == 9) begin
        fe_req  = 1'b1;
        fe_addr = 16'h0042;
      end
      sio_in = 4'(k);
      #1;
      if (k >= 9 && k <= 12) begin
        chk("f_rvld", {14'h0, fe_rvld, ex_rvld}, 16'h1);
        chk("f_rdata", 16'(rdata), 16'(k));
      end
      if (k >= 9 && k <= 13)
        chk("f_nognt", 16'(fe_gnt), 16'h0);
      if (k == 14) begin
        chk("f_gnt", {14'h0, fe_gnt, ex_gnt}, 16'h2);
        chk("f_idle", 16'(busy), 16'h0);
      end
    end
    tick();
    fe_req = 1'b0;
    w = 0;
    while (busy && w < 30) begin
      tick();
      #1;
      w++;
    end
    chk("f_end", 16'(busy), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
